// File: rtl/random_pkg.sv
// Shared definitions for the random_range generator: LFSR tap table, draw FSM
// states and the power-of-two rejection mask used by the range engine.
package random_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

  // Feedback tap masks for maximal-length Fibonacci LFSRs of the supported widths.
  function automatic logic [31:0] tap_mask(input int width);
    logic [31:0] taps;
    case (width)
      8:       taps = 32'h0000_00B8;  // bits 7,5,4,3
      24:      taps = 32'h00E1_0000;  // bits 23,22,21,16
      32:      taps = 32'h8020_0003;  // bits 31,21,1,0
      default: taps = 32'h0000_D008;  // bits 15,14,12,3
    endcase
    return taps;
  endfunction

  // Smallest 2^k-1 that covers bnd-1; a bound of 0 selects the full out_w range.
  function automatic logic [31:0] range_mask(input logic [31:0] bnd, input int out_w);
    logic [31:0] m;
    if (bnd == 32'd0) begin
      m = (out_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << out_w) - 32'd1);
    end else begin
      m = bnd - 32'd1;
      for (int i = 1; i < 32; i = i * 2) begin
        m = m | (m >> i);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/random_range_lfsr_step.sv
// Combinational LFSR next-state: table taps, all-zero lock-up escape and,
// when RANDOM_NOISE_EN is defined, mixing of the noise bit into feedback.
module lfsr_step
  import random_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] state,
  input  logic             noise,
  output logic [WIDTH-1:0] next_state
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(tap_mask(WIDTH));

  logic fb;

`ifdef RANDOM_NOISE_EN
  always_comb begin
    fb = ^(state & TAPS) ^ noise;
    if (state == '0) begin
      fb = 1'b1;
    end
  end
`else
  logic unused_noise;
  assign unused_noise = noise;

  always_comb begin
    fb = ^(state & TAPS);
    if (state == '0) begin
      fb = 1'b1;
    end
  end
`endif

  assign next_state = {state[WIDTH-2:0], fb};

endmodule

// File: rtl/random_range.sv
// Parametrised LFSR with seed loading and a rejection-sampling range engine.
// Optional macro RANDOM_NOISE_EN mixes the noise input into the feedback.
module random_range
  import random_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter int               OUT_W = 8,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             noise,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] random,
  input  logic             req,
  input  logic [OUT_W-1:0] bound,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] result
);

  logic [WIDTH-1:0] state_reg, state_next, lfsr_next;
  state_t           fsm_reg, fsm_next;
  logic [OUT_W-1:0] bnd_reg, mask_reg, result_reg;
  logic             valid_reg;
  logic [OUT_W-1:0] cand;
  logic             accept;
  logic             step;

  lfsr_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .state     (state_reg),
    .noise     (noise),
    .next_state(lfsr_next)
  );

  always_comb begin
    fsm_next = fsm_reg;
    cand     = state_reg[OUT_W-1:0] & mask_reg;
    accept   = (bnd_reg == '0) || (cand < bnd_reg);
    step     = en || (fsm_reg == DRAW);
    case (fsm_reg)
      IDLE: if (req) fsm_next = DRAW;
      DRAW: if (accept) fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
    // Seed loading wins over stepping, also in the middle of a draw.
    if (seed_load) begin
      state_next = seed;
    end else if (step) begin
      state_next = lfsr_next;
    end else begin
      state_next = state_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= SEED;
      fsm_reg    <= IDLE;
      bnd_reg    <= '0;
      mask_reg   <= '0;
      result_reg <= '0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      fsm_reg   <= fsm_next;
      valid_reg <= (fsm_reg == DRAW) && accept;
      if ((fsm_reg == IDLE) && req) begin
        bnd_reg  <= bound;
        mask_reg <= OUT_W'(range_mask(32'(bound), OUT_W));
      end
      if ((fsm_reg == DRAW) && accept) begin
        result_reg <= cand;
      end
    end
  end

  assign random = state_reg;
  assign busy   = (fsm_reg != IDLE);
  assign valid  = valid_reg;
  assign result = result_reg;

endmodule
